// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx: PS/2 keyboard receiver (sync, clock deglitch, 11-bit deframer) feeding a FWFT scancode FIFO.
// Latency: a good frame is visible on key/ready the clk cycle after the stop-bit fall event is processed.
// Backpressure: none toward the keyboard; a frame arriving at a full FIFO is dropped and sets sticky overflow.
// Build option: define PS2_MAKEBREAK_EN to fold 0xE0/0xF0 prefix bytes into key_flags instead of queueing them.
module ps2_scan_rx #(
   parameter int FIFO_AW        = 3,
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       rd,
   output logic [7:0] key,
   output logic [1:0] key_flags,
   output logic       ready,
   output logic       overflow,
   output logic [7:0] err_cnt,
   output logic       busy
);

   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int CW    = FIFO_AW + 1;
   localparam int FW    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   // ------------------------------------------------------------------
   // Pin synchronizers and clock deglitch filter
   // ------------------------------------------------------------------
   logic          clk_meta_q, clk_sync_q;
   logic          data_meta_q, data_sync_q;
   logic          filt_q;
   logic [FW-1:0] filt_cnt_q;
   logic          fall_q;

   // two-flop synchronizers for both asynchronous PS/2 pins
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         clk_meta_q  <= 1'b0;
         clk_sync_q  <= 1'b0;
         data_meta_q <= 1'b0;
         data_sync_q <= 1'b0;
      end else begin
         clk_meta_q  <= ps2_clk;
         clk_sync_q  <= clk_meta_q;
         data_meta_q <= ps2_data;
         data_sync_q <= data_meta_q;
      end
   end

   // filtered clock flips only after FILTER_LEN disagreeing samples in a row; a 1->0 flip emits a one-cycle fall
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         filt_q     <= 1'b0;
         filt_cnt_q <= '0;
         fall_q     <= 1'b0;
      end else begin
         fall_q <= 1'b0;
         if (clk_sync_q == filt_q) begin
            filt_cnt_q <= '0;
         end else if (filt_cnt_q == FILT_MAX) begin
            filt_q     <= clk_sync_q;
            filt_cnt_q <= '0;
            fall_q     <= filt_q;
         end else begin
            filt_cnt_q <= filt_cnt_q + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Frame deserializer
   // ------------------------------------------------------------------
   state_t        state_q;
   logic [7:0]    shift_q;
   logic [2:0]    bit_cnt_q;
   logic          par_q;
   logic          busy_q;
   logic [TW-1:0] to_cnt_q;
   logic [7:0]    err_cnt_q;

   logic          timeout_w;
   logic          at_stop_w;
   logic          frame_good_w;
   logic          frame_ok_w;
   logic          frame_bad_w;
   logic          push_w;
   logic [1:0]    push_flags_w;

   // a frame is good when the stop bit is high and data+parity carry an odd number of ones
   assign timeout_w    = (state_q != S_IDLE) && !fall_q && (to_cnt_q == TO_MAX);
   assign at_stop_w    = fall_q && (state_q == S_STOP);
   assign frame_good_w = data_sync_q && (^{shift_q, par_q});
   assign frame_ok_w   = at_stop_w && frame_good_w;
   assign frame_bad_w  = at_stop_w && !frame_good_w;

   // receive FSM, advanced only by fall events; a stall abandons the partial frame
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= S_IDLE;
         shift_q   <= 8'h00;
         bit_cnt_q <= 3'd0;
         par_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else if (timeout_w) begin
         state_q   <= S_IDLE;
         shift_q   <= 8'h00;
         bit_cnt_q <= 3'd0;
         busy_q    <= 1'b0;
      end else if (fall_q) begin
         case (state_q)
            S_IDLE: begin
               // a high data line on a fall is a spurious edge, not a start bit
               if (!data_sync_q) begin
                  state_q   <= S_DATA;
                  shift_q   <= 8'h00;
                  bit_cnt_q <= 3'd0;
                  busy_q    <= 1'b1;
               end
            end
            S_DATA: begin
               shift_q   <= {data_sync_q, shift_q[7:1]};
               bit_cnt_q <= bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_q <= S_PARITY;
               end
            end
            S_PARITY: begin
               par_q   <= data_sync_q;
               state_q <= S_STOP;
            end
            S_STOP: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // inter-edge watchdog: restarts on every fall, only advances while a frame is in progress
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         to_cnt_q <= '0;
      end else if (fall_q || (state_q == S_IDLE)) begin
         to_cnt_q <= '0;
      end else if (to_cnt_q != TO_MAX) begin
         to_cnt_q <= to_cnt_q + 1'b1;
      end
   end

   // saturating error counter for bad parity, bad stop bit and watchdog expiry
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         err_cnt_q <= 8'h00;
      end else if ((frame_bad_w || timeout_w) && (err_cnt_q != 8'hFF)) begin
         err_cnt_q <= err_cnt_q + 8'h01;
      end
   end

`ifdef PS2_MAKEBREAK_EN
   logic ext_pend_q, brk_pend_q;
   logic is_ext_w, is_brk_w;

   assign is_ext_w     = (shift_q == 8'hE0);
   assign is_brk_w     = (shift_q == 8'hF0);
   assign push_w       = frame_ok_w && !is_ext_w && !is_brk_w;
   assign push_flags_w = {ext_pend_q, brk_pend_q};

   // prefix bytes arm pending flags that ride along with the next real scancode
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ext_pend_q <= 1'b0;
         brk_pend_q <= 1'b0;
      end else if (frame_ok_w) begin
         if (is_ext_w) begin
            ext_pend_q <= 1'b1;
         end else if (is_brk_w) begin
            brk_pend_q <= 1'b1;
         end else begin
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
         end
      end else if (frame_bad_w || timeout_w) begin
         ext_pend_q <= 1'b0;
         brk_pend_q <= 1'b0;
      end
   end
`else
   assign push_w       = frame_ok_w;
   assign push_flags_w = 2'b00;
`endif

   // ------------------------------------------------------------------
   // First-word-fall-through scancode FIFO
   // ------------------------------------------------------------------
   logic [9:0]         mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               ovf_q;
   logic [9:0]         hold_q;
   logic [9:0]         head_w;
   logic               pop_w, full_w, wr_w;

   assign ready  = (cnt_q != '0);
   assign full_w = (cnt_q == FULL_CNT);
   assign pop_w  = rd && ready;
   // a pop in the same cycle frees the slot a push into a full FIFO needs
   assign wr_w   = push_w && (!full_w || pop_w);

   // occupancy next state
   always_comb begin
      cnt_d = cnt_q;
      case ({wr_w, pop_w})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // storage, pointers and occupancy
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 10'h000;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (wr_w) begin
            mem_q[wr_ptr_q] <= {push_flags_w, shift_q};
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop_w) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         cnt_q <= cnt_d;
      end
   end

   // sticky drop flag, cleared by the CPU reading an entry
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ovf_q <= 1'b0;
      end else if (pop_w) begin
         ovf_q <= 1'b0;
      end else if (push_w && full_w) begin
         ovf_q <= 1'b1;
      end
   end

   // last shown head is held so key/key_flags stay stable while the FIFO is empty
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hold_q <= 10'h000;
      end else begin
         hold_q <= head_w;
      end
   end

   assign head_w    = ready ? mem_q[rd_ptr_q] : hold_q;
   assign key       = head_w[7:0];
   assign key_flags = head_w[9:8];
   assign overflow  = ovf_q;
   assign err_cnt   = err_cnt_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// tb_ps2_scan_rx: self-checking bench for the PS/2 receiver and its scancode FIFO.
// Uses a short PS/2 bit period and a short watchdog so the whole run stays compact.
// Directed table, corner-case sequences, then random frames against a queue-based model.
module tb_ps2_scan_rx;

   localparam int TO   = 100;
   localparam int HALF = 10;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       rd = 1'b0;
   logic [7:0] key;
   logic [1:0] key_flags;
   logic       ready;
   logic       overflow;
   logic [7:0] err_cnt;
   logic       busy;

   int checks = 0;
   int errors = 0;

   ps2_scan_rx #(
      .FIFO_AW(3),
      .FILTER_LEN(4),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .ps2_clk(ps2_clk),
      .ps2_data(ps2_data),
      .rd(rd),
      .key(key),
      .key_flags(key_flags),
      .ready(ready),
      .overflow(overflow),
      .err_cnt(err_cnt),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] dat;
      bit         par_flip;
      bit         stop_bad;
      bit         pop;
      bit         exp_rdy;
      logic [7:0] exp_key;
      logic [7:0] exp_err;
      bit         exp_rdy_after;
      logic [7:0] exp_key_after;
   } vec_t;

   vec_t tbl[10];

   // reference model state
   logic [9:0] m_q[$];
   int         m_err;
   bit         m_ovf;
   bit         m_ext;
   bit         m_brk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // one PS/2 bit: data changes mid-high phase, then clock low for HALF cycles
   task automatic send_bit(input bit b);
      wait_cyc(HALF / 2);
      ps2_data = b;
      wait_cyc(HALF / 2);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop_bad);
      logic p;
      p = (~^d) ^ par_flip;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(p);
      send_bit(~stop_bad);
      ps2_data = 1'b1;
      wait_cyc(10);
   endtask

   task automatic pulse_rd();
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
   endtask

   task automatic model_frame(input logic [7:0] d, input bit good);
      logic [9:0] ent;
      if (!good) begin
         if (m_err < 255) m_err++;
         m_ext = 1'b0;
         m_brk = 1'b0;
         return;
      end
`ifdef PS2_MAKEBREAK_EN
      if (d == 8'hE0) begin m_ext = 1'b1; return; end
      if (d == 8'hF0) begin m_brk = 1'b1; return; end
      ent = {m_ext, m_brk, d};
      m_ext = 1'b0;
      m_brk = 1'b0;
`else
      ent = {2'b00, d};
`endif
      if (m_q.size() < 8) m_q.push_back(ent);
      else m_ovf = 1'b1;
   endtask

   initial begin
      int lat;
      int n;
      logic [7:0] d;
      bit good;
      int r;

      tbl[0] = '{8'h1C, 0, 0, 1, 1, 8'h1C, 8'd0, 0, 8'h1C};
      tbl[1] = '{8'h1C, 1, 0, 0, 0, 8'h1C, 8'd1, 0, 8'h1C};
      tbl[2] = '{8'h23, 0, 0, 1, 1, 8'h23, 8'd1, 0, 8'h23};
      tbl[3] = '{8'h00, 0, 0, 1, 1, 8'h00, 8'd1, 0, 8'h00};
      tbl[4] = '{8'hFF, 0, 0, 1, 1, 8'hFF, 8'd1, 0, 8'hFF};
      tbl[5] = '{8'h5A, 0, 1, 0, 0, 8'hFF, 8'd2, 0, 8'hFF};
      tbl[6] = '{8'hA5, 0, 0, 0, 1, 8'hA5, 8'd2, 1, 8'hA5};
      tbl[7] = '{8'h3C, 0, 0, 1, 1, 8'hA5, 8'd2, 1, 8'h3C};
      tbl[8] = '{8'h81, 0, 0, 1, 1, 8'h3C, 8'd2, 1, 8'h81};
      tbl[9] = '{8'h81, 0, 1, 1, 1, 8'h81, 8'd3, 0, 8'h81};

      // reset state
      wait_cyc(4);
      check("rst_key", key, 0);
      check("rst_flags", key_flags, 0);
      check("rst_ready", ready, 0);
      check("rst_ovf", overflow, 0);
      check("rst_err", err_cnt, 0);
      check("rst_busy", busy, 0);
      rstn = 1'b1;
      wait_cyc(10);

      // first frame 0x1C with push latency measured from the stop-bit clock fall
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(tbl[0].dat[i]);
      send_bit(1'b0);
      wait_cyc(HALF / 2);
      ps2_data = 1'b1;
      wait_cyc(HALF / 2);
      ps2_clk = 1'b0;
      wait_cyc(3);
      check("lat_early_ready", ready, 0);
      lat = 3;
      while (!ready && lat < 20) begin
         wait_cyc(1);
         lat++;
      end
      check("lat_ready_in_window", (lat >= 6 && lat <= 12) ? 1 : 0, 1);
      wait_cyc(HALF);
      ps2_clk = 1'b1;
      wait_cyc(10);
      check("lat_key", key, 8'h1C);
      check("lat_err", err_cnt, 0);
      pulse_rd();
      check("lat_pop_ready", ready, 0);

      // directed table
      for (int i = 0; i < 10; i++) begin
         send_frame(tbl[i].dat, tbl[i].par_flip, tbl[i].stop_bad);
         check($sformatf("tbl%0d_ready", i), ready, tbl[i].exp_rdy);
         check($sformatf("tbl%0d_key", i), key, tbl[i].exp_key);
         check($sformatf("tbl%0d_flags", i), key_flags, 0);
         check($sformatf("tbl%0d_err", i), err_cnt, tbl[i].exp_err);
         if (tbl[i].pop) begin
            pulse_rd();
            check($sformatf("tbl%0d_ready_after", i), ready, tbl[i].exp_rdy_after);
            check($sformatf("tbl%0d_key_after", i), key, tbl[i].exp_key_after);
         end
      end
      // rd with an empty FIFO is ignored
      pulse_rd();
      check("empty_rd_ready", ready, 0);
      check("empty_rd_key", key, 8'h81);

      // watchdog: start + 5 data bits, then the clock stalls high
      send_bit(1'b0);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      check("to_busy_mid", busy, 1);
      wait_cyc(TO - 40);
      check("to_busy_not_early", busy, 1);
      n = 0;
      while (busy && n < 100) begin
         wait_cyc(1);
         n++;
      end
      check("to_busy_dropped", busy, 0);
      check("to_err", err_cnt, 4);
      check("to_ready", ready, 0);
      send_frame(8'h1D, 0, 0);
      check("to_next_ready", ready, 1);
      check("to_next_key", key, 8'h1D);
      pulse_rd();

      // overflow: nine frames into an eight-deep FIFO
      for (int i = 1; i <= 9; i++) begin
         send_frame(8'(i), 0, 0);
         if (i == 8) check("ovf_before_drop", overflow, 0);
      end
      check("ovf_set", overflow, 1);
      check("ovf_head", key, 8'h01);
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("ovf_pop%0d_key", i), key, i);
         pulse_rd();
         if (i == 1) check("ovf_cleared", overflow, 0);
      end
      check("ovf_drained", ready, 0);

      // prefix bytes
`ifdef PS2_MAKEBREAK_EN
      send_frame(8'hF0, 0, 0);
      check("mb_f0_not_pushed", ready, 0);
      send_frame(8'h1C, 0, 0);
      check("mb1_key", key, 8'h1C);
      check("mb1_flags", key_flags, 2'b01);
      pulse_rd();
      check("mb1_single", ready, 0);
      send_frame(8'hE0, 0, 0);
      send_frame(8'hF0, 0, 0);
      send_frame(8'h75, 0, 0);
      check("mb2_key", key, 8'h75);
      check("mb2_flags", key_flags, 2'b11);
      pulse_rd();
      check("mb2_single", ready, 0);
`else
      send_frame(8'hF0, 0, 0);
      send_frame(8'h1C, 0, 0);
      check("raw_f0_key", key, 8'hF0);
      check("raw_f0_flags", key_flags, 0);
      pulse_rd();
      check("raw_1c_key", key, 8'h1C);
      pulse_rd();
      check("raw_empty", ready, 0);
`endif

      // reset during the 4th data bit, with one entry already queued
      send_frame(8'h11, 0, 0);
      check("mid_rst_pre_ready", ready, 1);
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      wait_cyc(HALF / 2);
      ps2_data = 1'b0;
      wait_cyc(HALF / 2);
      ps2_clk = 1'b0;
      wait_cyc(3);
      rstn = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      wait_cyc(HALF);
      rstn = 1'b1;
      wait_cyc(10);
      check("mid_rst_ready", ready, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_key", key, 0);
      send_frame(8'h29, 0, 0);
      check("mid_rst_key29", key, 8'h29);
      check("mid_rst_err", err_cnt, 0);
      pulse_rd();
      check("mid_rst_one_entry", ready, 0);

      // random frames against the model
      m_err = 0;
      m_ovf = 1'b0;
      m_ext = 1'b0;
      m_brk = 1'b0;
      for (int it = 0; it < 40; it++) begin
         r = $urandom_range(0, 5);
         if (r == 0) d = 8'hE0;
         else if (r == 1) d = 8'hF0;
         else d = 8'($urandom);
         r = $urandom_range(0, 7);
         good = (r > 1);
         send_frame(d, r == 0, r == 1);
         model_frame(d, good);
         check($sformatf("rnd%0d_ready", it), ready, (m_q.size() != 0) ? 1 : 0);
         check($sformatf("rnd%0d_err", it), err_cnt, m_err);
         check($sformatf("rnd%0d_ovf", it), overflow, m_ovf);
         n = $urandom_range(0, 2);
         for (int k = 0; k < n; k++) begin
            if (m_q.size() != 0) begin
               check($sformatf("rnd%0d_key", it), key, m_q[0][7:0]);
               check($sformatf("rnd%0d_flags", it), key_flags, m_q[0][9:8]);
               void'(m_q.pop_front());
               m_ovf = 1'b0;
            end
            pulse_rd();
         end
         check($sformatf("rnd%0d_ready_post", it), ready, (m_q.size() != 0) ? 1 : 0);
      end

      // error counter saturation via repeated watchdog expiries
      while (m_err < 257) begin
         send_bit(1'b0);
         wait_cyc(TO + 15);
         if (m_err < 255) begin
            m_err++;
         end else begin
            m_err++;
            if (m_err == 256) check("sat_reach", err_cnt, 255);
         end
      end
      check("sat_hold", err_cnt, 255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
